mux4: RTL and testbench



---
 rtl/mux4_if.sv | 23 ++
 rtl/mux4.sv | 40 ++++
 tb/tb_mux4.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mux4_if.sv
// mux4 bus bundle: select code, four data words, combinational and registered result.
// Ports: control, A, B, C, D (master drives); ou, ou_q (slave drives).
interface mux4_if #(
   parameter int WIDTH = 32
);
   logic [1:0]       control;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] C;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] ou;
   logic [WIDTH-1:0] ou_q;

   modport master (
      output control, A, B, C, D,
      input  ou, ou_q
   );

   modport slave (
      input  control, A, B, C, D,
      output ou, ou_q
   );
endinterface

// File: rtl/mux4.sv
// mux4: four-way WIDTH-bit selector with a combinational output and a registered copy.
// Ports: clk, rst_n (async active-low), bus (mux4_if.slave: control, A-D in; ou, ou_q out).
module mux4 #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst_n,
   mux4_if.slave bus
);

   logic [WIDTH-1:0] sel_w;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   // Default branch catches X/Z selects so ou reads as zero, never a stale word.
   always_comb begin
      sel_w = '0;
      case (bus.control)
         2'b00:   sel_w = bus.A;
         2'b01:   sel_w = bus.B;
         2'b10:   sel_w = bus.C;
         2'b11:   sel_w = bus.D;
         default: sel_w = '0;
      endcase
   end

   assign out_d  = sel_w;
   assign bus.ou = sel_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.ou_q = out_q;

endmodule

// File: tb/tb_mux4.sv
// tb_mux4: randomized self-checking bench for mux4 against a table-lookup model.
// Drives through mux4_if.master; checks ou after settle and ou_q after the next edge.
module tb_mux4;
   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   mux4_if #(.WIDTH(W)) bus ();

   mux4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: the selected word is simply the data table indexed by the code.
   function automatic logic [W-1:0] model(input logic [1:0] c,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] cc,
                                          input logic [W-1:0] d);
      logic [W-1:0] tbl [4];
      tbl[0] = a;
      tbl[1] = b;
      tbl[2] = cc;
      tbl[3] = d;
      return tbl[c];
   endfunction

   task automatic drive(input logic [1:0] c,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] cc,
                        input logic [W-1:0] d);
      bus.control = c;
      bus.A = a;
      bus.B = b;
      bus.C = cc;
      bus.D = d;
   endtask

   // Apply inputs, check ou after settle, then ou_q one edge later.
   task automatic step(input string tag,
                       input logic [1:0] c,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] cc,
                       input logic [W-1:0] d);
      logic [W-1:0] e;
      drive(c, a, b, cc, d);
      e = model(c, a, b, cc, d);
      #1;
      chk({tag, "_ou"}, bus.ou, e);
      @(posedge clk);
      #1;
      chk({tag, "_ou_q"}, bus.ou_q, e);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] rc;
      logic [W-1:0] rd;
      logic [1:0]   rs;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(2'b00, 32'd1, 32'd2, 32'd3, 32'd4);

      // Reset state
      @(posedge clk);
      #1;
      chk("reset_ou_q", bus.ou_q, '0);
      chk("reset_ou_live", bus.ou, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Static select with one settle delay each
      for (int i = 0; i < 4; i++) begin
         bus.control = 2'(i);
         #1;
         chk("static", bus.ou, 32'(i + 1));
      end

      // Registered path, one code per cycle
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step("reg_seq", 2'(i), 32'd1, 32'd2, 32'd3, 32'd4);
      end

      // Async reset mid-cycle
      step("pre_rst", 2'b11, 32'd1, 32'd2, 32'd3, 32'd4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_async_ou_q", bus.ou_q, '0);
      chk("rst_ou_follow", bus.ou, 32'd4);
      @(posedge clk);
      #1;
      chk("rst_hold_ou_q", bus.ou_q, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_release_ou_q", bus.ou_q, '0);
      @(posedge clk);
      #1;
      chk("rst_first_edge", bus.ou_q, 32'd4);

      // Isolation: non-selected inputs toggle, C selected
      drive(2'b10, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0);
      for (int i = 0; i < 20; i++) begin
         bus.A = $urandom;
         bus.B = $urandom;
         bus.D = $urandom;
         #1;
         chk("isolate", bus.ou, 32'hDEADBEEF);
      end

      // Full-width boundary values
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step("bound", 2'(i), 32'hFFFFFFFF, 32'h0,
              32'h80000000, 32'h00000001);
      end

      // Random stimulus
      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = $urandom;
         rd = $urandom;
         rs = 2'($urandom_range(0, 3));
         step("rand", rs, ra, rb, rc, rd);
      end

      // Unknown select: either resolution of bit 1 points at a zero word
      drive(2'bx1, 32'h12345678, 32'h0, 32'h9ABCDEF0, 32'h0);
      #1;
      chk("xsel_ou", bus.ou, '0);
      @(posedge clk);
      #1;
      chk("xsel_ou_q", bus.ou_q, '0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
